led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds a double-buffered hex value and sequences one digit per refresh slot. Each slot presents that digit's nibble on `bcd` to the downstream 7-segment decoder (4-bit hex in, active-low segments out) and drives the active-low digit enables and decimal point. New values are applied only at frame boundaries, so the display never tears.

## Interface
Parameters:
- `DIGITS`, 4, number of digits scanned (2..8)
- `DIV`, 50000, clock cycles per digit slot (>= 4)
- `BLANK`, 16, dead-time cycles at the start of each slot with all digits off (1..DIV-2)

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `value`  input  4*DIGITS  hex digits; nibble i = `value[4i+3:4i]`; digit 0 is least significant
- `dp`  input  DIGITS  decimal point request per digit, active-high
- `load`  input  1  single-cycle strobe; captures `value`/`dp` into the shadow register
- `blank_lz`  input  1  enables leading-zero blanking; sampled every cycle
- `bcd`  output  4  nibble for the current digit, to the decoder
- `digit_en`  output  DIGITS  digit anode enables, active-low
- `dp_n`  output  1  decimal point, active-low
- `pending`  output  1  shadow holds data not yet applied
- `frame_tick`  output  1  one-cycle pulse on the frame boundary

## Operation
- State:
  - prescaler `pcnt` counts 0..DIV-1
  - digit index `idx` counts 0..DIGITS-1
  - `shadow` register (value+dp)
  - `active` register (value+dp)
  - `pending` flag
- `pcnt` increments every cycle. At DIV-1 it wraps to 0 and `idx` advances; `idx` wraps from DIGITS-1 to 0.
- Frame boundary: the cycle where `pcnt`==DIV-1 and `idx`==DIGITS-1.
  - If `pending`: `active` <= `shadow` and `pending` <= 0.
- Load:
  - `load` outside a boundary: `shadow` <= inputs, `pending` <= 1. A later load before the boundary overwrites `shadow`; the last one wins.
  - `load` on a boundary cycle: inputs go directly into `active`, `shadow` is also updated, and `pending` <= 0.
- Leading-zero blanking: with `blank_lz`=1, digit i (i>0) is blanked when active nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit keeps its enable high and `dp_n` high, even if its dp bit is set.
- Slot output, for the slot of digit `idx`:
  - When `pcnt` < BLANK or the digit is blanked: `digit_en` is all ones and `dp_n`=1.
  - Otherwise `digit_en` has bit `idx` low and all others high, and `dp_n`=~active dp[idx].
  - `bcd`=active nibble[idx] for the whole slot, including dead time.
- Reset state:
  - counters = 0, `shadow`/`active` = 0, `pending`=0
  - `bcd`=0, `digit_en`=all ones, `dp_n`=1, `frame_tick`=0
- Reset asserted mid-frame discards any pending data, and scanning restarts at digit 0, `pcnt`=0.

## Timing
- All outputs are registered and reflect counter/active state with 1-cycle latency.
- After `reset` deasserts, the first edge has `pcnt`=0, `idx`=0. Outputs show digit 0 in dead time from the next cycle on. `digit_en[0]` first goes low BLANK+1 cycles after reset release.
- `frame_tick` is high the cycle after the boundary, which is the same cycle the outputs first show digit 0 of the new frame.
- `pending` rises the cycle after `load` and falls the cycle after the boundary.
- Newly applied data is visible on `bcd` together with `frame_tick`.
- Frame period is DIGITS*DIV cycles. Each digit is lit DIV-BLANK cycles per frame.
- Only one bit of `digit_en` is ever low at a time, and it is never low during a dead-time cycle.

## Test plan
All scenarios use DIGITS=4, DIV=8, BLANK=2.
- Reset then idle:
  - `digit_en`=4'b1111 for 3 cycles, then 4'b1110 for 6 cycles.
  - `bcd`=0 and `dp_n`=1 throughout.
  - The first `frame_tick` arrives 33 cycles after reset release.
- Load `value`=16'h1234, `dp`=4'b0100 mid-frame:
  - `pending`=1 until the boundary.
  - The next frame shows `bcd` 4,3,2,1 on `digit_en` 1110,1101,1011,0111.
  - `dp_n`=0 only during digit 2's lit cycles.
- Two loads in one frame (16'hAAAA, then 16'hBEEF): only 16'hBEEF is displayed, and `pending` clears once.
- `load` of 16'h5678 exactly on the boundary cycle: 16'h5678 appears in the immediately following frame, and `pending` never asserts.
- `blank_lz`=1 with `value`=16'h0070: digits 3 and 2 stay dark with `dp_n`=1 even if `dp`=4'b1111, and digits 1 and 0 light with `bcd`=7 and 0. With `value`=0, only digit 0 lights.
- `reset` asserted during digit 2 with data pending: all outputs return to their reset values on the next cycle, `pending`=0, and after release the display shows 0 with the pending data lost.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
//   Scan controller for a common-anode multi-digit 7-segment display.
//   Holds a double-buffered hex value (shadow -> active) and lights one digit
//   per refresh slot. Each slot starts with BLANK dead-time cycles in which
//   every digit is off. New data is applied only at the frame boundary, so a
//   frame never mixes old and new digits.
//
// Parameters
//   DIGITS : number of scanned digits (2..8)
//   DIV    : clock cycles per digit slot (>= 4)
//   BLANK  : dead-time cycles at the start of each slot (1..DIV-2)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   value      in   4*DIGITS hex nibbles, digit 0 in value[3:0]
//   dp         in   per-digit decimal point request, active-high
//   load       in   one-cycle strobe capturing value/dp
//   blank_lz   in   leading-zero blanking enable, sampled every cycle
//   bcd        out  nibble of the current digit, to the segment decoder
//   digit_en   out  digit anode enables, active-low
//   dp_n       out  decimal point, active-low
//   pending    out  shadow holds data not yet applied
//   frame_tick out  one-cycle pulse marking the start of a new frame
module led_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  dp_n,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PCNT_LIT  = PW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Scan counters
  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;

  // Double buffer
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] active_val;
  logic [DIGITS-1:0]   active_dp;

  // Boundary seen last cycle; frame_tick follows one cycle later so that it
  // lines up with the first registered output of digit 0.
  logic tick_arm;

  logic slot_end;
  logic boundary;

  assign slot_end = (pcnt == PCNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / active buffers
  // A load landing exactly on the boundary bypasses the shadow stage so the
  // data shows in the very next frame and pending never rises.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
        active_val <= value;
        active_dp  <= dp;
        pending    <= 1'b0;
      end else if (pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
        pending    <= 1'b0;
      end
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp;
      pending    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask: walk from the most significant nibble downwards; a
  // digit is dark while every nibble at or above it is zero. Digit 0 is
  // never masked.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] lz_dark;

  always_comb begin
    logic zero_run;
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (active_val[4*(DIGITS-1-k) +: 4] == 4'h0);
      if (k < DIGITS - 1) begin
        lz_dark[DIGITS-1-k] = zero_run && blank_lz;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit selection
  // ---------------------------------------------------------------------------
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_dark;

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib  = active_val[4*k +: 4];
        cur_dp   = active_dp[k];
        cur_dark = lz_dark[k];
      end
    end
  end

  logic              lit;
  logic [DIGITS-1:0] en_lit;

  assign lit    = (pcnt >= PCNT_LIT) && !cur_dark;
  assign en_lit = ~(DIGITS'(1) << idx);

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd        <= '0;
      digit_en   <= '1;
      dp_n       <= 1'b1;
      tick_arm   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      bcd        <= cur_nib;
      digit_en   <= lit ? en_lit : '1;
      dp_n       <= lit ? ~cur_dp : 1'b1;
      tick_arm   <= boundary;
      frame_tick <= tick_arm;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Testbench for led_scan_ctrl (DIGITS=4, DIV=8, BLANK=2).
// The reference model tracks the frame position as a plain edge count since
// reset release and derives every expected output from it arithmetically.
module tb_led_scan_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 8;
  localparam int unsigned BLANK  = 2;
  localparam int unsigned FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;

  led_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .bcd(bcd), .digit_en(digit_en), .dp_n(dp_n),
    .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int unsigned checks = 0;
  int unsigned passes = 0;

  // reference model state
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, s_dp;
  logic        m_pend;
  int unsigned n;        // edges since reset release; n % FRAME = position
  logic [3:0]  e_bcd, e_en;
  logic        e_dpn, e_ft;

  // observation helpers
  logic        prev_pend = 1'b0;
  int unsigned pend_rises, pend_falls;
  int unsigned lit_cnt[4];
  int unsigned dpl_cnt[4];
  logic [3:0]  nib_seen[4];
  int unsigned dark_dp;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      passes++;
  endtask

  task automatic tick();
    int unsigned s, mi, mp;
    logic dark;
    @(posedge clk);
    if (reset) begin
      m_val = '0; m_dp = '0; s_val = '0; s_dp = '0; m_pend = 1'b0; n = 0;
      e_bcd = '0; e_en = 4'hF; e_dpn = 1'b1; e_ft = 1'b0;
    end else begin
      s  = n % FRAME;
      mi = s / DIV;
      mp = s % DIV;
      e_bcd = 4'((m_val >> (4*mi)) & 16'h000F);
      dark  = blank_lz && (mi > 0) && ((m_val >> (4*mi)) == 16'h0000);
      if (mp < BLANK || dark) begin
        e_en = 4'hF; e_dpn = 1'b1;
      end else begin
        e_en = ~(4'b0001 << mi); e_dpn = ~m_dp[mi];
      end
      e_ft = (n > 0) && (((n - 1) % FRAME) == FRAME - 1);
      if (s == FRAME - 1) begin
        if (load) begin
          m_val = value; m_dp = dp; s_val = value; s_dp = dp; m_pend = 1'b0;
        end else if (m_pend) begin
          m_val = s_val; m_dp = s_dp; m_pend = 1'b0;
        end
      end else if (load) begin
        s_val = value; s_dp = dp; m_pend = 1'b1;
      end
      n++;
    end
    #1;
    chk("bcd", 16'(bcd), 16'(e_bcd));
    chk("digit_en", 16'(digit_en), 16'(e_en));
    chk("dp_n", 16'(dp_n), 16'(e_dpn));
    chk("frame_tick", 16'(frame_tick), 16'(e_ft));
    chk("pending", 16'(pending), 16'(m_pend));
    if (!prev_pend && pending) pend_rises++;
    if (prev_pend && !pending) pend_falls++;
    prev_pend = pending;
  endtask

  task automatic go_to(input int unsigned target);
    for (int i = 0; i < 2*FRAME && (n % FRAME) != target; i++) tick();
    chk("go_to_reached", 16'(n % FRAME), 16'(target));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Run through the boundary cycle; the next tick is digit 0 of a new frame.
  task automatic run_to_boundary();
    go_to(FRAME - 1);
    tick();
  endtask

  // Observe one whole frame, recording lit cycles per digit.
  task automatic observe_frame();
    int unsigned d;
    logic found;
    for (int k = 0; k < 4; k++) begin
      lit_cnt[k] = 0; dpl_cnt[k] = 0; nib_seen[k] = 4'hX;
    end
    dark_dp = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (c == 0) chk("frame_start_tick", 16'(frame_tick), 16'd1);
      if (digit_en == 4'hF) begin
        if (!dp_n) dark_dp++;
      end else begin
        found = 1'b0; d = 0;
        for (int k = 0; k < 4; k++)
          if (digit_en == ~(4'b0001 << k)) begin found = 1'b1; d = k; end
        chk("enable_onehot", 16'(found), 16'd1);
        if (found) begin
          lit_cnt[d]++;
          nib_seen[d] = bcd;
          if (!dp_n) dpl_cnt[d]++;
        end
      end
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [3:0]  en;
    logic [3:0]  nib;
    logic        dpn;
    logic        ft;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] exp_nib[4];

    // ---------------- reset then idle (table-driven) ----------------
    tbl.push_back('{0,  4'hF, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{1,  4'hF, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{2,  4'hF, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{3,  4'hE, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{8,  4'hE, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{9,  4'hF, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{32, 4'h7, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{33, 4'hF, 4'h0, 1'b1, 1'b1});

    for (int unsigned k = 0; k <= 33; k++) begin
      reset = (k == 0);
      tick();
      foreach (tbl[i]) begin
        if (tbl[i].cyc == k) begin
          chk("idle_en", 16'(digit_en), 16'(tbl[i].en));
          chk("idle_bcd", 16'(bcd), 16'(tbl[i].nib));
          chk("idle_dpn", 16'(dp_n), 16'(tbl[i].dpn));
          chk("idle_tick", 16'(frame_tick), 16'(tbl[i].ft));
        end
      end
    end

    // ---------------- mid-frame load ----------------
    go_to(10);
    do_load(16'h1234, 4'b0100);
    chk("load_pending", 16'(pending), 16'd1);
    while ((n % FRAME) != FRAME - 1) begin
      tick();
      chk("pending_hold", 16'(pending), 16'd1);
    end
    tick();
    chk("pending_clear", 16'(pending), 16'd0);
    observe_frame();
    exp_nib = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 4; k++) begin
      chk("lit_cycles", 16'(lit_cnt[k]), 16'(DIV - BLANK));
      chk("nibble", 16'(nib_seen[k]), 16'(exp_nib[k]));
      chk("dp_lit", 16'(dpl_cnt[k]), (k == 2) ? 16'(DIV - BLANK) : 16'd0);
    end
    chk("dp_dark", 16'(dark_dp), 16'd0);

    // ---------------- two loads in one frame ----------------
    go_to(5);
    pend_falls = 0; pend_rises = 0;
    do_load(16'hAAAA, 4'b0000);
    go_to(20);
    do_load(16'hBEEF, 4'b0000);
    run_to_boundary();
    observe_frame();
    exp_nib = '{4'hF, 4'hE, 4'hE, 4'hB};
    for (int k = 0; k < 4; k++) chk("last_load_wins", 16'(nib_seen[k]), 16'(exp_nib[k]));
    chk("pending_falls_once", 16'(pend_falls), 16'd1);

    // ---------------- load on boundary ----------------
    go_to(FRAME - 1);
    pend_rises = 0;
    do_load(16'h5678, 4'b0000);
    chk("boundary_load_no_pend", 16'(pending), 16'd0);
    observe_frame();
    exp_nib = '{4'h8, 4'h7, 4'h6, 4'h5};
    for (int k = 0; k < 4; k++) chk("boundary_nibble", 16'(nib_seen[k]), 16'(exp_nib[k]));
    chk("boundary_no_rise", 16'(pend_rises), 16'd0);

    // ---------------- leading-zero blanking ----------------
    blank_lz = 1'b1;
    go_to(3);
    do_load(16'h0070, 4'b1111);
    run_to_boundary();
    observe_frame();
    chk("lz_d3_dark", 16'(lit_cnt[3]), 16'd0);
    chk("lz_d2_dark", 16'(lit_cnt[2]), 16'd0);
    chk("lz_d1_lit", 16'(lit_cnt[1]), 16'(DIV - BLANK));
    chk("lz_d0_lit", 16'(lit_cnt[0]), 16'(DIV - BLANK));
    chk("lz_d1_nib", 16'(nib_seen[1]), 16'h7);
    chk("lz_d0_nib", 16'(nib_seen[0]), 16'h0);
    chk("lz_dark_dp", 16'(dark_dp), 16'd0);
    go_to(3);
    do_load(16'h0000, 4'b0000);
    run_to_boundary();
    observe_frame();
    for (int k = 1; k < 4; k++) chk("lz_zero_dark", 16'(lit_cnt[k]), 16'd0);
    chk("lz_zero_d0", 16'(lit_cnt[0]), 16'(DIV - BLANK));
    blank_lz = 1'b0;

    // ---------------- reset mid-frame with pending data ----------------
    go_to(12);
    do_load(16'h9999, 4'b1111);
    go_to(19);
    reset = 1'b1;
    tick();
    chk("rst_en", 16'(digit_en), 16'hF);
    chk("rst_bcd", 16'(bcd), 16'h0);
    chk("rst_dpn", 16'(dp_n), 16'd1);
    chk("rst_pend", 16'(pending), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    reset = 1'b0;
    pend_rises = 0;
    run_to_boundary();
    observe_frame();
    for (int k = 0; k < 4; k++) chk("rst_data_lost", 16'(nib_seen[k]), 16'h0);
    chk("rst_no_pend", 16'(pend_rises), 16'd0);

    // ---------------- randomized ----------------
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom);
      dp    = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    load = 1'b0;
    reset = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
